// File: rtl/audio_channel_out.sv
// One audio output channel: AUDC control register, distortion-selected output
// flip-flop, optional high-pass flip-flop and the 4-bit volume contribution.
module audio_channel_out (
   input  logic       clk,
   input  logic       nRST,
   input  logic       enn,
   input  logic [7:0] D,
   input  logic       WR,
   input  logic       BOR,
   input  logic       P4,
   input  logic       P5,
   input  logic       P17,
   input  logic       HPE,
   input  logic       HPC,
   output logic       CH,
   output logic [3:0] AUD
);

   logic [7:0] audc_r;
   logic       ch_r;
   logic       hf_r;
   logic [7:0] audc_next_s;
   logic       ch_next_s;
   logic       hf_next_s;
   logic       gate_s;

   // Volume contribution from control bits and the (optionally filtered) output bit.
   function automatic logic [3:0] volume_out(input logic [7:0] audc,
                                              input logic       ch,
                                              input logic       hf,
                                              input logic       hpe);
      logic f;
      f = hpe ? (ch ^ hf) : ch;
      if (audc[4] == 1'b1) begin
         volume_out = audc[3:0];
      end else begin
         volume_out = f ? audc[3:0] : 4'd0;
      end
   endfunction

   // Next-state logic; the output bit always uses the pre-write distortion mode.
   always_comb begin
      audc_next_s = audc_r;
      ch_next_s   = ch_r;
      hf_next_s   = hf_r;
      gate_s      = audc_r[7] | P5;
      if (WR == 1'b1) begin
         audc_next_s = D;
      end else begin
         audc_next_s = audc_r;
      end
      if ((BOR == 1'b1) && (gate_s == 1'b1)) begin
         case ({audc_r[6], audc_r[5]})
            2'b01, 2'b11: ch_next_s = ~ch_r;
            2'b10:        ch_next_s = P4;
            2'b00:        ch_next_s = P17;
            default:      ch_next_s = ch_r;
         endcase
      end else begin
         ch_next_s = ch_r;
      end
      if (HPE == 1'b0) begin
         hf_next_s = 1'b0;
      end else if (HPC == 1'b1) begin
         hf_next_s = ch_r;
      end else begin
         hf_next_s = hf_r;
      end
   end

   // State register: falling-edge clocked, gated by the cycle enable.
   always_ff @(negedge clk or negedge nRST) begin
      if (!nRST) begin
         audc_r <= 8'h00;
         ch_r   <= 1'b0;
         hf_r   <= 1'b0;
      end else if (enn) begin
         audc_r <= audc_next_s;
         ch_r   <= ch_next_s;
         hf_r   <= hf_next_s;
      end
   end

   assign CH  = ch_r;
   assign AUD = volume_out(audc_r, ch_r, hf_r, HPE);

endmodule

// File: tb/tb_audio_channel_out.sv
// Directed plus randomized bench for audio_channel_out against a behavioural
// model of the channel rules.
module tb_audio_channel_out;

   logic       clk;
   logic       n_rst;
   logic       enn;
   logic [7:0] d;
   logic       wr;
   logic       bor;
   logic       p4;
   logic       p5;
   logic       p17;
   logic       hpe;
   logic       hpc;
   logic       ch;
   logic [3:0] aud;

   int n_checks;
   int n_fail;

   logic [7:0] m_audc;
   logic       m_ch;
   logic       m_hf;

   audio_channel_out dut (
      .clk  (clk),
      .nRST (n_rst),
      .enn  (enn),
      .D    (d),
      .WR   (wr),
      .BOR  (bor),
      .P4   (p4),
      .P5   (p5),
      .P17  (p17),
      .HPE  (hpe),
      .HPC  (hpc),
      .CH   (ch),
      .AUD  (aud)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Channel rules applied to one enabled edge, using the state before the edge.
   task automatic model_edge();
      int  mode;
      bit  pass;
      logic new_ch;
      logic new_hf;
      mode   = int'(m_audc) / 32;
      pass   = (mode >= 4) || (p5 == 1'b1);
      new_ch = m_ch;
      if (bor && pass) begin
         if (mode % 2 == 1)       new_ch = !m_ch;
         else if (mode % 4 == 2)  new_ch = p4;
         else                     new_ch = p17;
      end
      new_hf = m_hf;
      if (!hpe)     new_hf = 1'b0;
      else if (hpc) new_hf = m_ch;
      if (wr) m_audc = d;
      m_ch = new_ch;
      m_hf = new_hf;
   endtask

   function automatic logic [3:0] exp_aud();
      logic f;
      int   vol;
      vol = int'(m_audc) % 16;
      f   = hpe ? (m_ch != m_hf) : m_ch;
      if ((int'(m_audc) / 16) % 2 == 1) return 4'(vol);
      return f ? 4'(vol) : 4'd0;
   endfunction

   task automatic model_clear();
      m_audc = 8'h00;
      m_ch   = 1'b0;
      m_hf   = 1'b0;
   endtask

   task automatic tick(input string tag);
      @(negedge clk);
      if (!n_rst)   model_clear();
      else if (enn) model_edge();
      #1;
      check({tag, "_ch"},  {7'd0, ch},  {7'd0, m_ch});
      check({tag, "_aud"}, {4'd0, aud}, {4'd0, exp_aud()});
   endtask

   task automatic idle();
      wr  = 1'b0;
      bor = 1'b0;
      hpc = 1'b0;
   endtask

   initial begin
      logic [3:0] tone_exp [4];
      logic       p4_seq   [3];
      logic [3:0] p4_aud   [3];
      logic       ch_before;
      n_checks = 0;
      n_fail   = 0;
      tone_exp = '{4'd8, 4'd0, 4'd8, 4'd0};
      p4_seq   = '{1'b1, 1'b0, 1'b1};
      p4_aud   = '{4'd5, 4'd0, 4'd5};
      n_rst = 1'b0; enn = 1'b1; d = 8'h00; wr = 1'b0; bor = 1'b0;
      p4 = 1'b0; p5 = 1'b0; p17 = 1'b0; hpe = 1'b0; hpc = 1'b0;
      model_clear();
      #2;
      check("reset_ch",  {7'd0, ch},  8'h00);
      check("reset_aud", {4'd0, aud}, 8'h00);
      wr = 1'b1; d = 8'hA8; bor = 1'b1;
      tick("in_reset");
      tick("in_reset");
      idle();
      n_rst = 1'b1;

      // Pure tone
      wr = 1'b1; d = 8'hA8; tick("wr_a8"); idle();
      for (int k = 0; k < 4; k++) begin
         repeat (3) tick("tone_gap");
         bor = 1'b1; tick("tone_bor"); idle();
         check("tone_aud", {4'd0, aud}, {4'd0, tone_exp[k]});
      end

      // Poly5 gating
      p5 = 1'b0;
      wr = 1'b1; d = 8'h2F; tick("wr_2f"); idle();
      for (int k = 0; k < 3; k++) begin
         bor = 1'b1; tick("p5_block"); idle();
         check("p5_block_ch",  {7'd0, ch},  8'h00);
         check("p5_block_aud", {4'd0, aud}, 8'h00);
      end
      p5 = 1'b1; bor = 1'b1; tick("p5_pass"); idle();
      check("p5_pass_ch",  {7'd0, ch},  8'h01);
      check("p5_pass_aud", {4'd0, aud}, 8'h0F);

      // Poly4 select
      p5 = 1'b0;
      wr = 1'b1; d = 8'hC5; tick("wr_c5"); idle();
      for (int k = 0; k < 3; k++) begin
         p4 = p4_seq[k]; bor = 1'b1; tick("p4_bor"); idle();
         check("p4_ch",  {7'd0, ch},  {7'd0, p4_seq[k]});
         check("p4_aud", {4'd0, aud}, {4'd0, p4_aud[k]});
      end

      // Volume-only mode keeps the output bit moving underneath
      wr = 1'b1; d = 8'h17; tick("wr_17"); idle();
      p5 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ch_before = m_ch;
         p17 = !m_ch; bor = 1'b1; tick("volonly"); idle();
         check("volonly_aud", {4'd0, aud}, 8'h07);
         check("volonly_ch",  {7'd0, ch},  {7'd0, !ch_before});
      end

      // High-pass filter
      p5 = 1'b0; hpe = 1'b1;
      wr = 1'b1; d = 8'hAF; tick("wr_af"); idle();
      if (m_ch !== 1'b1) begin
         bor = 1'b1; tick("hp_prep"); idle();
      end
      check("hp_ch1", {7'd0, ch}, 8'h01);
      hpc = 1'b1; tick("hp_hpc"); idle();
      check("hp_hf_aud", {4'd0, aud}, 8'h00);
      bor = 1'b1; tick("hp_bor"); idle();
      check("hp_bor_ch",  {7'd0, ch},  8'h00);
      check("hp_bor_aud", {4'd0, aud}, 8'h0F);
      hpc = 1'b1; bor = 1'b1; tick("hp_both"); idle();
      check("hp_both_ch",  {7'd0, ch},  8'h01);
      check("hp_both_aud", {4'd0, aud}, 8'h0F);
      hpc = 1'b1; tick("hp_set"); idle();
      check("hp_set_aud", {4'd0, aud}, 8'h00);
      hpe = 1'b0; tick("hp_off");
      hpe = 1'b1; tick("hp_on");
      check("hp_forced_aud", {4'd0, aud}, 8'h0F);

      // Write/borrow collision, then mid-waveform reset
      hpe = 1'b0;
      wr = 1'b1; d = 8'h00; tick("wr_00"); idle();
      p5 = 1'b1; p17 = 1'b0; bor = 1'b1; tick("p17_zero"); idle();
      wr = 1'b1; d = 8'hA3; bor = 1'b1; p17 = 1'b1; tick("collide"); idle();
      check("collide_ch",  {7'd0, ch},  8'h01);
      check("collide_aud", {4'd0, aud}, 8'h03);
      bor = 1'b1; tick("new_mode"); idle();
      check("new_mode_ch", {7'd0, ch}, 8'h00);
      bor = 1'b1; tick("new_mode2"); idle();
      #2;
      n_rst = 1'b0;
      model_clear();
      #1;
      check("async_rst_ch",  {7'd0, ch},  8'h00);
      check("async_rst_aud", {4'd0, aud}, 8'h00);
      wr = 1'b1; d = 8'hFF; bor = 1'b1; hpe = 1'b1; hpc = 1'b1;
      tick("rst_edges");
      tick("rst_edges");
      idle(); hpe = 1'b0;
      #2;
      n_rst = 1'b1;
      p5 = 1'b0; bor = 1'b1; tick("post_rst"); idle();
      check("post_rst_ch", {7'd0, ch}, 8'h00);

      // Cycle enable
      wr = 1'b1; d = 8'hA8; tick("wr_a8b"); idle();
      bor = 1'b1; tick("en_bor"); idle();
      enn = 1'b0; wr = 1'b1; d = 8'h17; bor = 1'b1; hpe = 1'b1; hpc = 1'b1;
      tick("enn_low");
      tick("enn_low");
      check("enn_hold_ch",  {7'd0, ch},  8'h01);
      check("enn_hold_aud", {4'd0, aud}, 8'h08);
      idle(); enn = 1'b1; hpe = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         enn = ($urandom_range(0, 9) != 0);
         wr  = ($urandom_range(0, 7) == 0);
         d   = 8'($urandom);
         bor = ($urandom_range(0, 2) == 0);
         hpc = ($urandom_range(0, 3) == 0);
         p4  = 1'($urandom_range(0, 1));
         p5  = 1'($urandom_range(0, 1));
         p17 = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) hpe = !hpe;
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
